// File: rtl/hamming_pkg.sv
// Shared constants, data-position table and syndrome/encode helpers for the
// 15/11 Hamming link; used by both the transmit encoder and the receive decoder.
package hamming_pkg;

   localparam int HAM_N = 15;
   localparam int HAM_K = 11;
   localparam int HAM_P = 4;

   // Hamming position (1-based) of data bit i is DATA_POS[i*HAM_P +: HAM_P].
   localparam logic [HAM_K*HAM_P-1:0] DATA_POS = {
      4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
   };

   typedef struct packed {
      logic [HAM_K-1:0] data;
      logic [HAM_N-1:0] codeword;
      logic [HAM_P-1:0] syndrome;
      logic             err;
   } dec_result_t;

   function automatic logic [HAM_P-1:0] data_pos(input int i);
      return DATA_POS[i*HAM_P +: HAM_P];
   endfunction

   function automatic logic [HAM_P-1:0] ham_syndrome(input logic [HAM_N-1:0] cw);
      logic [HAM_P-1:0] s;
      s = '0;
      for (int p = 1; p <= HAM_N; p++) begin
         if (cw[p-1]) s = s ^ HAM_P'(p);
      end
      return s;
   endfunction

   // Parity positions start at zero, so the syndrome of the data-only word
   // is exactly the set of parity bits that makes the final syndrome zero.
   function automatic logic [HAM_N-1:0] ham_encode(input logic [HAM_K-1:0] data);
      logic [HAM_N-1:0] cw;
      logic [HAM_P-1:0] s;
      cw = '0;
      for (int i = 0; i < HAM_K; i++) begin
         cw[data_pos(i) - 4'd1] = data[i];
      end
      s = ham_syndrome(cw);
      for (int k = 0; k < HAM_P; k++) begin
         cw[(1 << k) - 1] = s[k];
      end
      return cw;
   endfunction

endpackage

// File: rtl/hamming_15_11_dec.sv
// Combinational 15/11 Hamming decode: syndrome, single-bit correction and
// data extraction from a captured codeword.
module hamming_15_11_dec
   import hamming_pkg::*;
(
   input  logic [HAM_N-1:0] cw,
   output dec_result_t      res
);

   logic [HAM_P-1:0] syn;
   logic [HAM_N-1:0] corr;
   logic [HAM_K-1:0] data;

   always_comb begin
      syn  = ham_syndrome(cw);
      corr = cw;
      // A non-zero syndrome names the 1-based position to flip.
      if (syn != '0) corr[syn - 4'd1] = ~cw[syn - 4'd1];
      data = '0;
      for (int i = 0; i < HAM_K; i++) begin
         data[i] = corr[data_pos(i) - 4'd1];
      end
   end

   assign res.data     = data;
   assign res.codeword = corr;
   assign res.syndrome = syn;
   assign res.err      = (syn != '0);

endmodule

// File: rtl/hamming_rx_decoder.sv
// Receive side of the 15/11 Hamming link: deserialize, capture, decode, register.
// Optional saturating error counter enabled by macro HAMMING_RX_ERRCNT_EN.
module hamming_rx_decoder
   import hamming_pkg::*;
(
   input  logic             clk,
   input  logic             RST,
   input  logic             sl_in,
   input  logic             shift,
   input  logic             align,
   output logic [HAM_K-1:0] data_out,
   output logic [HAM_N-1:0] codeword_out,
   output logic [HAM_P-1:0] syndrome,
   output logic             err_flag,
   output logic             data_valid,
   output logic [3:0]       bit_count
`ifdef HAMMING_RX_ERRCNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   // Handshake: shift is a valid-only qualifier with no backpressure, one bit
   // accepted on every edge where shift=1; data_valid is push-only, high for
   // exactly one cycle per frame and qualifying all decoded outputs.

   logic [HAM_N-1:0] sreg;
   logic [HAM_N-1:0] sreg_nxt;
   logic [HAM_N-1:0] cw_q;
   logic [3:0]       count_nxt;
   logic             last_bit;
   logic             frame_rdy;
   dec_result_t      dec;

   always_comb begin
      sreg_nxt  = sreg;
      count_nxt = bit_count;
      last_bit  = 1'b0;
      if (align) begin
         // A bit arriving with align starts the new frame as its bit 0.
         sreg_nxt  = shift ? {sl_in, {(HAM_N-1){1'b0}}} : '0;
         count_nxt = shift ? 4'd1 : 4'd0;
      end else if (shift) begin
         sreg_nxt = {sl_in, sreg[HAM_N-1:1]};
         if (bit_count == 4'(HAM_N - 1)) begin
            count_nxt = 4'd0;
            last_bit  = 1'b1;
         end else begin
            count_nxt = bit_count + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         sreg      <= '0;
         bit_count <= '0;
         cw_q      <= '0;
         frame_rdy <= 1'b0;
      end else begin
         sreg      <= sreg_nxt;
         bit_count <= count_nxt;
         frame_rdy <= last_bit;
         if (last_bit) cw_q <= sreg_nxt;
      end
   end

   hamming_15_11_dec u_dec (
      .cw  (cw_q),
      .res (dec)
   );

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         data_out     <= '0;
         codeword_out <= '0;
         syndrome     <= '0;
         err_flag     <= 1'b0;
         data_valid   <= 1'b0;
      end else begin
         data_valid <= frame_rdy;
         if (frame_rdy) begin
            data_out     <= dec.data;
            codeword_out <= dec.codeword;
            syndrome     <= dec.syndrome;
            err_flag     <= dec.err;
         end
      end
   end

`ifdef HAMMING_RX_ERRCNT_EN
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         err_count <= '0;
      end else if (data_valid && err_flag && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Self-checking bench for hamming_rx_decoder: directed scenarios plus a
// randomized frame stream checked against a rule-level reference model.
module tb_hamming_rx_decoder;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic        sl_in = 1'b0;
   logic        shift = 1'b0;
   logic        align = 1'b0;
   logic [10:0] data_out;
   logic [14:0] codeword_out;
   logic [3:0]  syndrome;
   logic        err_flag;
   logic        data_valid;
   logic [3:0]  bit_count;
`ifdef HAMMING_RX_ERRCNT_EN
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   hamming_rx_decoder dut (
      .clk          (clk),
      .RST          (RST),
      .sl_in        (sl_in),
      .shift        (shift),
      .align        (align),
      .data_out     (data_out),
      .codeword_out (codeword_out),
      .syndrome     (syndrome),
      .err_flag     (err_flag),
      .data_valid   (data_valid),
      .bit_count    (bit_count)
`ifdef HAMMING_RX_ERRCNT_EN
      ,
      .err_count    (err_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state; entries are {data, corrected cw, syndrome, err}.
   logic [30:0] exp_q[$];
   logic [14:0] m_bits;
   int          m_cnt;
   logic        m_due;
   logic        exp_valid;
   logic [30:0] m_out;

   function automatic logic [30:0] ref_decode(input logic [14:0] cw);
      int          s;
      int          j;
      logic [14:0] corr;
      logic [10:0] d;
      s = 0;
      for (int p = 1; p <= 15; p++) if (cw[p-1]) s = s ^ p;
      corr = cw;
      if (s != 0) corr[s-1] = ~corr[s-1];
      d = '0;
      j = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = corr[p-1];
            j++;
         end
      end
      return {d, corr, 4'(s), (s != 0)};
   endfunction

   function automatic logic [14:0] ref_encode(input logic [10:0] d);
      logic [14:0] cw;
      int          j;
      int          s;
      cw = '0;
      j = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[j];
            j++;
         end
      end
      s = 0;
      for (int p = 1; p <= 15; p++) if (cw[p-1]) s = s ^ p;
      for (int k = 0; k < 4; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
      return cw;
   endfunction

   task automatic step(input logic sh, input logic b, input logic al);
      @(negedge clk);
      shift = sh;
      sl_in = b;
      align = al;
      @(posedge clk);
      #1;
      exp_valid = m_due;
      m_due = 1'b0;
      if (exp_valid) m_out = exp_q.pop_front();
      if (al) m_cnt = 0;
      if (sh) begin
         m_bits[m_cnt] = b;
         m_cnt++;
         if (m_cnt == 15) begin
            exp_q.push_back(ref_decode(m_bits));
            m_due = 1'b1;
            m_cnt = 0;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      RST = 1'b0;
      shift = 1'b0;
      align = 1'b0;
      sl_in = 1'b0;
      #1;
      exp_q.delete();
      m_cnt = 0;
      m_due = 1'b0;
      exp_valid = 1'b0;
      m_out = '0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({data_out, codeword_out, syndrome, err_flag} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", {data_out, codeword_out, syndrome, err_flag});
      end
      n_checks++;
      if (data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b expected 0", data_valid);
      end
      n_checks++;
      if (bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_bit_count: got %0d expected 0", bit_count);
      end
`ifdef HAMMING_RX_ERRCNT_EN
      n_checks++;
      if (err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_err_count: got %0d expected 0", err_count);
      end
`endif
      release_reset();
   endtask

   task automatic test_single_frame(input string name, input logic [14:0] cw,
                                    input logic [10:0] e_data, input logic [14:0] e_cw,
                                    input logic [3:0] e_syn, input logic e_err);
      for (int i = 0; i < 15; i++) step(1'b1, cw[i], 1'b0);
      n_checks++;
      if (data_valid !== 1'b0 || bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL %s_last_edge: got valid=%b count=%0d expected valid=0 count=0", name, data_valid, bit_count);
      end
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_valid: got %b expected 1", name, data_valid);
      end
      n_checks++;
      if ({data_out, codeword_out, syndrome, err_flag} !== {e_data, e_cw, e_syn, e_err}) begin
         n_fail++;
         $display("FAIL %s_decode: got data=%h cw=%h syn=%0d err=%b expected data=%h cw=%h syn=%0d err=%b",
                  name, data_out, codeword_out, syndrome, err_flag, e_data, e_cw, e_syn, e_err);
      end
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (data_valid !== 1'b0 || data_out !== e_data) begin
         n_fail++;
         $display("FAIL %s_hold: got valid=%b data=%h expected valid=0 data=%h", name, data_valid, data_out, e_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] frames [2];
      int          t_valid[$];
      logic [10:0] d_valid[$];
      frames[0] = 15'h0007;
      frames[1] = 15'h0000;
      for (int t = 0; t < 32; t++) begin
         if (t < 30) step(1'b1, frames[t / 15][t % 15], 1'b0);
         else step(1'b0, 1'b0, 1'b0);
         if (data_valid === 1'b1) begin
            t_valid.push_back(t);
            d_valid.push_back(data_out);
         end
      end
      n_checks++;
      if (t_valid.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d expected 2", t_valid.size());
      end else begin
         n_checks++;
         if (t_valid[0] != 15 || t_valid[1] - t_valid[0] != 15) begin
            n_fail++;
            $display("FAIL b2b_timing: got cycles %0d,%0d expected 15,30", t_valid[0], t_valid[1]);
         end
         n_checks++;
         if (d_valid[0] !== 11'h001 || d_valid[1] !== 11'h000) begin
            n_fail++;
            $display("FAIL b2b_data: got %h,%h expected 001,000", d_valid[0], d_valid[1]);
         end
      end
   endtask

   task automatic test_align();
      logic [14:0] f;
      int          n_valid;
      logic [10:0] d_seen;
      f = 15'h7FEF;
      for (int i = 0; i < 15; i++) step(1'b1, f[i], 1'b0);
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (data_valid !== 1'b1 || syndrome !== 4'd5) begin
         n_fail++;
         $display("FAIL align_keeps_captured: got valid=%b syn=%0d expected valid=1 syn=5", data_valid, syndrome);
      end
      for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (bit_count !== 4'd1) begin
         n_fail++;
         $display("FAIL align_bit_count: got %0d expected 1", bit_count);
      end
      f = 15'h0007;
      n_valid = 0;
      d_seen = '0;
      for (int i = 1; i < 17; i++) begin
         if (i < 15) step(1'b1, f[i], 1'b0);
         else step(1'b0, 1'b0, 1'b0);
         if (data_valid === 1'b1) begin
            n_valid++;
            d_seen = data_out;
         end
      end
      n_checks++;
      if (n_valid != 1 || d_seen !== 11'h001) begin
         n_fail++;
         $display("FAIL align_frame: got pulses=%0d data=%h expected pulses=1 data=001", n_valid, d_seen);
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] f;
      int          n_valid;
      f = 15'h7FFF;
      for (int i = 0; i < 10; i++) step(1'b1, f[i], 1'b0);
      apply_reset();
      n_checks++;
      if ({data_out, codeword_out, syndrome, err_flag, data_valid, bit_count} !== 36'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got data=%h cw=%h syn=%0d err=%b valid=%b count=%0d expected all 0",
                  data_out, codeword_out, syndrome, err_flag, data_valid, bit_count);
      end
      release_reset();
      for (int i = 0; i < 15; i++) step(1'b1, f[i], 1'b0);
      apply_reset();
      release_reset();
      n_valid = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (data_valid !== 1'b0) n_valid++;
      end
      n_checks++;
      if (n_valid != 0) begin
         n_fail++;
         $display("FAIL midreset_pending_dropped: got %0d pulses expected 0", n_valid);
      end
      n_valid = 0;
      for (int i = 0; i < 17; i++) begin
         if (i < 15) step(1'b1, f[i], 1'b0);
         else step(1'b0, 1'b0, 1'b0);
         if (data_valid === 1'b1) n_valid++;
      end
      n_checks++;
      if (n_valid != 1 || data_out !== 11'h7FF || err_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_recover: got pulses=%0d data=%h err=%b expected pulses=1 data=7ff err=0",
                  n_valid, data_out, err_flag);
      end
   endtask

   task automatic test_random();
      logic [2:0]  stim[$];
      logic [14:0] cw;
      int          nerr;
      int          start;
      for (int f = 0; f < 40; f++) begin
         cw = ref_encode(11'($urandom));
         nerr = $urandom_range(0, 2);
         for (int e = 0; e < nerr; e++) cw[$urandom_range(0, 14)] ^= 1'b1;
         start = 0;
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(1, 13)) stim.push_back({1'b1, 1'($urandom), 1'b0});
            if ($urandom_range(0, 1) == 1) begin
               stim.push_back({1'b1, cw[0], 1'b1});
               start = 1;
            end else begin
               stim.push_back(3'b001);
            end
         end
         for (int i = start; i < 15; i++) begin
            if ($urandom_range(0, 3) == 0) stim.push_back(3'b000);
            stim.push_back({1'b1, cw[i], 1'b0});
         end
      end
      stim.push_back(3'b000);
      stim.push_back(3'b000);
      for (int i = 0; i < stim.size(); i++) begin
         step(stim[i][2], stim[i][1], stim[i][0]);
         n_checks++;
         if (data_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL rand_valid[%0d]: got %b expected %b", i, data_valid, exp_valid);
         end
         n_checks++;
         if ({data_out, codeword_out, syndrome, err_flag} !== m_out) begin
            n_fail++;
            $display("FAIL rand_outputs[%0d]: got %h expected %h", i, {data_out, codeword_out, syndrome, err_flag}, m_out);
         end
         n_checks++;
         if (bit_count !== 4'(m_cnt)) begin
            n_fail++;
            $display("FAIL rand_bit_count[%0d]: got %0d expected %0d", i, bit_count, m_cnt);
         end
      end
   endtask

`ifdef HAMMING_RX_ERRCNT_EN
   task automatic test_errcnt();
      logic [14:0] cw;
      apply_reset();
      release_reset();
      for (int f = 0; f < 4; f++) begin
         cw = ref_encode(11'($urandom));
         if (f != 2) cw[$urandom_range(0, 14)] ^= 1'b1;
         for (int i = 0; i < 15; i++) step(1'b1, cw[i], 1'b0);
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (err_count !== 16'd3) begin
         n_fail++;
         $display("FAIL err_count: got %0d expected 3", err_count);
      end
   endtask
`endif

   initial begin
      m_cnt = 0;
      m_due = 1'b0;
      exp_valid = 1'b0;
      m_out = '0;
      m_bits = '0;
      test_reset();
      test_single_frame("clean", 15'h7FFF, 11'h7FF, 15'h7FFF, 4'd0, 1'b0);
      test_single_frame("single_err", 15'h7FEF, 11'h7FF, 15'h7FFF, 4'd5, 1'b1);
      test_back_to_back();
      test_align();
      test_reset_mid();
      test_random();
`ifdef HAMMING_RX_ERRCNT_EN
      test_errcnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hamming_rx_decoder.md
# hamming_rx_decoder

- Receive-side stage of the 11/15 Hamming link: consumes the serial codeword stream produced by the transmit path (codeword bit 0 first) and deserializes each 15-bit frame.
- Computes the 4-bit syndrome, corrects any single-bit error, and presents the 11 data bits with a one-cycle valid strobe.
- Sits directly downstream of the transmit serializer, driven by the same clock.

## Interface
- Parameters: none; widths are fixed by the shared package (N=15, K=11).
- `clk`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-low reset.
- `sl_in`  in  1  serial codeword bit, sampled when `shift`=1.
- `shift`  in  1  bit-valid; one codeword bit accepted per cycle with `shift`=1.
- `align`  in  1  synchronous frame realign; discards any partial frame.
- `data_out`  out  11  decoded, corrected data bits.
- `codeword_out`  out  15  corrected codeword (bit i = Hamming position i+1).
- `syndrome`  out  4  raw syndrome of the captured frame.
- `err_flag`  out  1  syndrome non-zero, i.e. one bit corrected.
- `data_valid`  out  1  single-cycle strobe qualifying all of the above.
- `bit_count`  out  4  bits collected in the current frame, 0..14.

## Operation
- **Deserializer:** 15-bit shift register, shifts right; `sl_in` enters bit 14. After 15 shifts, bit 0 holds the first-received bit.
- **Bit counter:** counts accepted bits 0..14.
  - On the shift that supplies the 15th bit, the assembled word (including the incoming bit) loads into capture register `cw_q`.
  - On that same shift, the counter wraps to 0 and `frame_rdy` is set.
- **Decode (combinational on `cw_q`):**
  - Syndrome bit k = XOR of all positions p (1..15) with bit k of p set.
  - Syndrome S≠0: flip position S. S=0: no change.
  - Data mapping: positions 3,5,6,7,9,10,11,12,13,14,15 → `data_out[0..10]`.
- **Output register:** the cycle after `frame_rdy`, register `data_out`, `codeword_out`, `syndrome` and `err_flag`, and pulse `data_valid` for one cycle. Outputs hold their value until the next frame.
- **Frame state:**
  - COLLECT: counter < 15. This is the only state.
  - The `frame_rdy`/`data_valid` pipeline runs alongside COLLECT, so the next frame collects while the previous one decodes.
- **`align`:**
  - Clears the counter and discards the partial frame.
  - `align` together with `shift` in the same cycle: the bit is taken as bit 0 of the new frame (`bit_count` becomes 1).
  - A frame already captured in `cw_q` still produces its `data_valid`.
- **Reset:** all outputs, the counter, the shift register, `cw_q` and `frame_rdy` are 0. Asserting `RST` mid-frame discards the frame and any pending `data_valid`.
- **Double-bit errors:** indistinguishable from single-bit errors; the block miscorrects and sets `err_flag`. This is accepted behaviour.

## Timing
- Edge E samples the 15th bit, setting `cw_q` and `frame_rdy`.
- Edge E+1 registers the outputs; `data_valid` is high from E+1 to E+2.
- Latency: 1 cycle after the last bit's edge.
- Back-to-back frames with `shift` held high give one `data_valid` every 15 cycles.
- Gaps (`shift`=0) stall collection and have no other effect.
- `bit_count` is registered and reflects the state after each edge.

## Configuration
- Macro: `HAMMING_RX_ERRCNT_EN`.
- Defined: adds output `err_count` [15:0].
  - Increments on each `data_valid` with `err_flag`=1.
  - Saturates at 16'hFFFF.
  - Cleared by `RST` only.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `hamming_pkg` holds:
  - constants `HAM_N`=15, `HAM_K`=11, `HAM_P`=4;
  - the data-position table;
  - the syndrome function.
  - The transmit encoder shares this package.
- Sub-module `hamming_15_11_dec`: purely combinational syndrome, correction and extraction on `cw_q`.
- Top level keeps the deserializer, counter, `align` logic and output registers.

## Test plan
- Shift 15'h7FFF (data 11'h7FF), LSB first, `shift` held high → one cycle after the 15th bit: `data_out`=11'h7FF, `syndrome`=0, `err_flag`=0, `data_valid` one cycle.
- Shift 15'h7FEF (position 5 flipped) → `syndrome`=4'd5, `err_flag`=1, `codeword_out`=15'h7FFF, `data_out`=11'h7FF.
- Shift 15'h0007, then immediately 15'h0000 → `data_out`=11'h001, then 11'h000; `data_valid` pulses exactly 15 cycles apart.
- Shift 7 bits, then pulse `align` with `shift`=1 and `sl_in`=1, then 14 bits of 15'h0007 → `bit_count`=1 after the align edge; a single frame decodes to `data_out`=11'h001.
- Assert `RST` low after 10 bits of a frame → all outputs 0, no `data_valid`; the next full 15'h7FFF decodes normally.
- With `HAMMING_RX_ERRCNT_EN`: send 3 frames each with one flipped bit → `err_count`=3.
